// File: rtl/mc_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mc_sram_ctrl
//
// Single-port on-chip memory endpoint. Accepts one read or write request per
// cycle and returns exactly one response per request, in acceptance order.
// After every reset the memory is swept to zero, one word per cycle. Requests
// are credit-limited so that every accepted request already owns a slot in
// the response path and no response is ever lost under back-pressure.
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst_n               synchronous reset, active low
//   i_receive_addr_valid  request valid
//   i_receive_addr        word address (low MEM_DEPTH_LOG bits used)
//   i_receive_data_valid  1 = write i_receive_data, 0 = read
//   i_receive_data        write data (ignored on reads)
//   o_receive_ready       request accepted when high with i_receive_addr_valid
//   o_send_valid          response valid
//   o_send_data           read data, or the write data echoed back
//   i_send_ready          response consumed when high with o_send_valid
// ---------------------------------------------------------------------------
module mc_sram_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH_LOG = 10,
    parameter int RESP_DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_receive_addr_valid,
    input  logic [ADDR_WIDTH-1:0] i_receive_addr,
    input  logic                  i_receive_data_valid,
    input  logic [DATA_WIDTH-1:0] i_receive_data,
    output logic                  o_receive_ready,
    output logic                  o_send_valid,
    output logic [DATA_WIDTH-1:0] o_send_data,
    input  logic                  i_send_ready
);

    localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG;
    localparam int PTR_W     = $clog2(RESP_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [CNT_W-1:0]         DEPTH_C  = CNT_W'(RESP_DEPTH);
    localparam logic [MEM_DEPTH_LOG-1:0] CLR_LAST = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [MEM_DEPTH_LOG-1:0] r_clr_cnt;

    // Memory port
    logic [DATA_WIDTH-1:0]    r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]    r_mem_rdata;
    logic                     w_mem_en;
    logic                     w_mem_we;
    logic [MEM_DEPTH_LOG-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]    w_mem_wdata;

    // Stage 1: one cycle behind acceptance, waiting for the registered read
    logic                  r_s1_valid;
    logic                  r_s1_is_wr;
    logic [DATA_WIDTH-1:0] r_s1_wdata;
    logic [DATA_WIDTH-1:0] w_s1_data;

    // Response FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [RESP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_cnt;

    // Requests accepted but not yet popped (stage 1 + FIFO)
    logic [CNT_W-1:0]      r_outst;

    logic w_accept;
    logic w_pop;

    // Upper address bits are deliberately ignored (addresses alias).
    logic w_unused_addr;
    assign w_unused_addr = ^i_receive_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG];

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ready depends on registered state only, never on the handshake inputs.
    always_comb begin
        w_state_next    = r_state;
        o_receive_ready = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_receive_ready = (r_outst < DEPTH_C);
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign w_accept = o_receive_ready & i_receive_addr_valid;
    assign w_pop    = o_send_valid & i_send_ready;

    // -----------------------------------------------------------------------
    // Memory port: the clear sweep owns the port during INIT, requests in RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = i_receive_addr[MEM_DEPTH_LOG-1:0];
        w_mem_wdata = i_receive_data;
        if (r_state == ST_INIT) begin
            w_mem_en    = i_rst_n;
            w_mem_we    = i_rst_n;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = '0;
        end else if (w_accept && i_rst_n) begin
            w_mem_en = 1'b1;
            w_mem_we = i_receive_data_valid;
        end
    end

    // Single-port array with registered read. A write returns its own data,
    // so the read-during-write value is never used.
    always_ff @(posedge i_clk) begin
        if (w_mem_en) begin
            if (w_mem_we) begin
                r_mem[w_mem_addr] <= w_mem_wdata;
            end
            r_mem_rdata <= r_mem[w_mem_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_is_wr <= 1'b0;
            r_s1_wdata <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_is_wr <= i_receive_data_valid;
                r_s1_wdata <= i_receive_data;
            end
        end
    end

    assign w_s1_data = r_s1_is_wr ? r_s1_wdata : r_mem_rdata;

    // -----------------------------------------------------------------------
    // Response FIFO (show-ahead). Overflow cannot happen: stage 1 plus FIFO
    // occupancy never exceeds RESP_DEPTH because of the credit limit.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (r_s1_valid) begin
            r_fifo_data[r_wr_ptr] <= w_s1_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (r_s1_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({r_s1_valid, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_outst <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    assign o_send_valid = (r_fifo_cnt != '0);
    // Data is forced to zero while empty so stale entries never show after reset.
    assign o_send_data  = o_send_valid ? r_fifo_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_mc_sram_ctrl.sv
module tb_mc_sram_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MDL = 4;
    localparam int RD  = 4;
    localparam int NW  = 1 << MDL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_receive_addr_valid;
    logic [AW-1:0] i_receive_addr;
    logic          i_receive_data_valid;
    logic [DW-1:0] i_receive_data;
    logic          o_receive_ready;
    logic          o_send_valid;
    logic [DW-1:0] o_send_data;
    logic          i_send_ready;

    always #5 clk = ~clk;

    mc_sram_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MEM_DEPTH_LOG (MDL),
        .RESP_DEPTH    (RD)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_receive_addr_valid (i_receive_addr_valid),
        .i_receive_addr       (i_receive_addr),
        .i_receive_data_valid (i_receive_data_valid),
        .i_receive_data       (i_receive_data),
        .o_receive_ready      (o_receive_ready),
        .o_send_valid         (o_send_valid),
        .o_send_data          (o_send_data),
        .i_send_ready         (i_send_ready)
    );

    // Reference model: word array, queue of expected responses tagged with
    // the edge number at which each request was accepted.
    typedef struct {
        logic [DW-1:0] d;
        int            k;
    } ent_t;

    logic [DW-1:0] ref_mem [NW];
    ent_t          q [$];
    int            n_vec    = 0;
    int            n_err    = 0;
    int            edge_cnt = 0;
    int            rel      = 0;   // edges seen with reset released
    logic          post_rst = 1'b1;
    logic          last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // One clock cycle: check outputs against the model, advance the edge,
    // update the model, return at the falling edge.
    task automatic tick();
        logic exp_rdy, exp_vld, acc, pop, wr;
        logic [DW-1:0] wd;
        int idx;
        exp_rdy = (rel >= NW) && (q.size() < RD);
        exp_vld = (q.size() > 0) && (q[0].k + 1 <= edge_cnt);
        chk("ready", 32'(o_receive_ready), 32'(exp_rdy));
        chk("send_valid", 32'(o_send_valid), 32'(exp_vld));
        if (exp_vld && o_send_valid) chk("send_data", o_send_data, q[0].d);
        if (post_rst) chk("rst_data", o_send_data, 32'h0);
        acc = o_receive_ready && i_receive_addr_valid;
        pop = o_send_valid && i_send_ready;
        wr  = i_receive_data_valid;
        wd  = i_receive_data;
        idx = int'(i_receive_addr % NW);
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < NW; i++) ref_mem[i] = '0;
            rel      = 0;
            post_rst = 1'b1;
            last_acc = 1'b0;
        end else begin
            post_rst = 1'b0;
            if (pop && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                if (wr) ref_mem[idx] = wd;
                q.push_back('{d: (wr ? wd : ref_mem[idx]), k: edge_cnt});
            end
            if (rel < NW) rel++;
            last_acc = acc;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_receive_addr_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_req(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        i_receive_addr_valid = 1'b1;
        i_receive_addr       = a;
        i_receive_data_valid = wr;
        i_receive_data       = d;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (last_acc) break;
        end
        chk("req_accept", 32'(last_acc), 32'h1);
        i_receive_addr_valid = 1'b0;
    endtask

    task automatic drain();
        i_send_ready         = 1'b1;
        i_receive_addr_valid = 1'b0;
        for (int n = 0; n < 100 && q.size() > 0; n++) tick();
        chk("drained", 32'(q.size()), 32'h0);
    endtask

    initial begin
        int idx;
        int nacc;
        rst_n                = 1'b0;
        i_receive_addr_valid = 1'b0;
        i_receive_addr       = '0;
        i_receive_data_valid = 1'b0;
        i_receive_data       = '0;
        i_send_ready         = 1'b1;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held for 3 cycles, then the clear sweep
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        idle(20);

        // Read / write / read of the same word, back to back
        send_req(32'd5, 1'b0, 32'h0);
        send_req(32'd5, 1'b1, 32'hDEADBEEF);
        send_req(32'd5, 1'b0, 32'h0);
        drain();

        // Aliasing
        send_req(32'h13, 1'b1, 32'h12345678);
        send_req(32'h03, 1'b0, 32'h0);
        drain();

        // Back-pressure
        for (int i = 0; i < 6; i++) send_req(32'(i), 1'b1, 32'(32'hA0 + i));
        drain();
        i_send_ready = 1'b0;
        idx = 0;
        for (int n = 0; n < 10; n++) begin
            i_receive_addr_valid = 1'b1;
            i_receive_addr       = 32'(idx);
            i_receive_data_valid = 1'b0;
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_ready_low", 32'(o_receive_ready), 32'h0);
        i_send_ready = 1'b1;
        for (int n = 0; n < 50 && idx < 6; n++) begin
            i_receive_addr_valid = 1'b1;
            i_receive_addr       = 32'(idx);
            tick();
            if (last_acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd6);
        drain();

        // Random traffic with random back-pressure
        nacc = 0;
        i_receive_addr_valid = 1'b1;
        i_receive_addr       = $urandom;
        i_receive_data_valid = 1'($urandom_range(0, 1));
        i_receive_data       = $urandom;
        for (int n = 0; n < 20000 && nacc < 1000; n++) begin
            i_send_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) begin
                nacc++;
                i_receive_addr       = $urandom;
                i_receive_data_valid = 1'($urandom_range(0, 1));
                i_receive_data       = $urandom;
            end
        end
        chk("rand_count", 32'(nacc), 32'd1000);
        drain();

        // Reset with three responses outstanding, then re-init
        send_req(32'd7, 1'b1, 32'h00000055);
        drain();
        i_send_ready = 1'b0;
        send_req(32'd1, 1'b0, 32'h0);
        send_req(32'd2, 1'b0, 32'h0);
        send_req(32'd3, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        i_send_ready = 1'b1;
        send_req(32'd7, 1'b0, 32'h0);   // held during INIT, accepted only in RUN
        drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
